// File: rtl/spi_cfg_receiver.sv
// SPI mode-0 configuration receiver. Accepted frames wait in per-target pending
// buffers and are applied to ch_cfg/global_cfg on the next sample_tick.
module spi_cfg_receiver #(
    parameter int                  N_CHANNELS   = 8,
    parameter int                  CH_WIDTH     = 96,
    parameter int                  GLOBAL_WIDTH = 64,
    parameter logic [CH_WIDTH-1:0] AUTOCLR_MASK = '0,
    parameter int                  SYNC_STAGES  = 2
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             sample_tick,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    input  logic                             spi_csn,
    output logic                             spi_miso,
    output logic [N_CHANNELS*CH_WIDTH-1:0]   ch_cfg,
    output logic [GLOBAL_WIDTH-1:0]          global_cfg,
    output logic                             cfg_update,
    output logic                             frame_err,
    output logic [7:0]                       status
);

    localparam int MAXW    = (CH_WIDTH > GLOBAL_WIDTH) ? CH_WIDTH : GLOBAL_WIDTH;
    localparam int CNT_MAX = 8 + MAXW + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
    logic                   sclk_prev_q, csn_prev_q;
    logic                   sclk_s, mosi_s, csn_s;
    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [7:0]       hdr_q;
    logic [MAXW-1:0]  pay_q;
    logic [7:0]       miso_sr_q;
    logic             err_sticky_q, ovr_sticky_q;
    logic [5:0]       frame_cnt_q;
    logic             cfg_update_q, frame_err_q;

    logic [N_CHANNELS-1:0][CH_WIDTH-1:0] ch_pend_q, ch_cfg_q;
    logic [N_CHANNELS-1:0]               ch_flag_q, ch_load;
    logic [GLOBAL_WIDTH-1:0]             glb_pend_q, glb_cfg_q;
    logic                                glb_flag_q;

    logic active, in_check, capture, shift_en;
    logic idx_ok, glb_ok, ch_ok, accept_glb, accept_ch, reject, overrun_hit, any_pend;

    // The csn synchroniser clears to 0, so a csn that is high at reset release
    // looks like a rising edge; IDLE ignores it, and a frame already in flight
    // at release is skipped until csn falls again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s     = csn_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csn_rise  = csn_s & ~csn_prev_q;
    assign csn_fall  = ~csn_s & csn_prev_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (csn_fall) state_d = ST_HEADER;
            ST_HEADER: begin
                if (csn_rise)
                    state_d = ST_CHECK;
                else if (sclk_rise && bit_cnt_q == CNT_W'(7))
                    state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: if (csn_rise) state_d = ST_CHECK;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign active   = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign in_check = (state_q == ST_CHECK);
    assign capture  = (state_q == ST_IDLE) && csn_fall;
    assign shift_en = active && sclk_rise && !csn_rise;

    assign idx_ok     = 32'(hdr_q[6:0]) < N_CHANNELS;
    assign glb_ok     = hdr_q[7] && (bit_cnt_q == CNT_W'(8 + GLOBAL_WIDTH));
    assign ch_ok      = !hdr_q[7] && (bit_cnt_q == CNT_W'(8 + CH_WIDTH)) && idx_ok;
    assign accept_glb = in_check && glb_ok;
    assign accept_ch  = in_check && ch_ok;
    assign reject     = in_check && !(glb_ok || ch_ok);

    always_comb begin
        ch_load = '0;
        for (int k = 0; k < N_CHANNELS; k++)
            ch_load[k] = accept_ch && (32'(hdr_q[6:0]) == k);
    end

    // A pending flag that this same tick is applying does not count as overrun.
    assign overrun_hit = !sample_tick &&
                         ((accept_glb && glb_flag_q) || (|(ch_load & ch_flag_q)));
    assign any_pend    = glb_flag_q || (|ch_flag_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            hdr_q        <= '0;
            pay_q        <= '0;
            miso_sr_q    <= '0;
            err_sticky_q <= 1'b0;
            ovr_sticky_q <= 1'b0;
            frame_cnt_q  <= '0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_err_q  <= reject;
            cfg_update_q <= sample_tick && any_pend;

            if (capture) begin
                bit_cnt_q <= '0;
                hdr_q     <= '0;
            end else if (shift_en) begin
                if (bit_cnt_q != CNT_W'(CNT_MAX))
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                if (state_q == ST_HEADER)
                    hdr_q <= {hdr_q[6:0], mosi_s};
                else
                    pay_q <= {pay_q[MAXW-2:0], mosi_s};
            end

            if (capture)
                miso_sr_q <= {err_sticky_q, ovr_sticky_q, frame_cnt_q};
            else if (in_check)
                miso_sr_q <= '0;
            else if (active && sclk_fall)
                miso_sr_q <= {miso_sr_q[6:0], 1'b0};

            // Reading the status byte clears the sticky flags after capture.
            if (capture) begin
                err_sticky_q <= 1'b0;
                ovr_sticky_q <= 1'b0;
            end
            if (reject)
                err_sticky_q <= 1'b1;
            if (overrun_hit)
                ovr_sticky_q <= 1'b1;
            if (accept_glb || accept_ch)
                frame_cnt_q <= frame_cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            glb_pend_q <= '0;
            glb_flag_q <= 1'b0;
            glb_cfg_q  <= '0;
        end else begin
            if (accept_glb)
                glb_pend_q <= pay_q[GLOBAL_WIDTH-1:0];
            if (accept_glb)
                glb_flag_q <= 1'b1;
            else if (sample_tick)
                glb_flag_q <= 1'b0;
            if (sample_tick && glb_flag_q)
                glb_cfg_q <= glb_pend_q;
        end
    end

    // Channels not reloaded on a tick drop their self-clearing command bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch_pend_q <= '0;
            ch_flag_q <= '0;
            ch_cfg_q  <= '0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                if (ch_load[k])
                    ch_pend_q[k] <= pay_q[CH_WIDTH-1:0];
                if (ch_load[k])
                    ch_flag_q[k] <= 1'b1;
                else if (sample_tick)
                    ch_flag_q[k] <= 1'b0;
                if (sample_tick)
                    ch_cfg_q[k] <= ch_flag_q[k] ? ch_pend_q[k]
                                                : (ch_cfg_q[k] & ~AUTOCLR_MASK);
            end
        end
    end

    assign spi_miso   = miso_sr_q[7];
    assign ch_cfg     = ch_cfg_q;
    assign global_cfg = glb_cfg_q;
    assign cfg_update = cfg_update_q;
    assign frame_err  = frame_err_q;
    assign status     = {err_sticky_q, ovr_sticky_q, frame_cnt_q};

endmodule
